// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel 3x3 window buffer.
// Holds the FSM state encoding, pixel width and default image size.
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 64;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL      = 2'd0;
  localparam state_t ST_ISSUE     = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixels; combinational read and synchronous write at the same index.
// The read returns the old contents in the cycle the new pixel is written.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Raster pixels in, 3x3 window out; start pulses 1 cycle after the completing pixel and input
// stalls until the gradient core returns done. Define WINDOW_COUNT_EN to add o_window_count.
module sobel_window_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_pixel_valid,
  input  logic [PIX_W-1:0] i_pixel,
  output logic             o_pixel_ready,
  input  logic             i_gradient_data_ready,
  output logic             o_gradient_start,
  output logic [PIX_W-1:0] P0,
  output logic [PIX_W-1:0] P1,
  output logic [PIX_W-1:0] P2,
  output logic [PIX_W-1:0] P3,
  output logic [PIX_W-1:0] P4,
  output logic [PIX_W-1:0] P5,
  output logic [PIX_W-1:0] P6,
  output logic [PIX_W-1:0] P7,
  output logic [PIX_W-1:0] P8,
`ifdef WINDOW_COUNT_EN
  output logic [15:0]      o_window_count,
`endif
  output logic             o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             accept;
  logic             last_col;
  logic             last_pix;
  logic             win_done;
  logic [PIX_W-1:0] rd1;
  logic [PIX_W-1:0] rd2;
  logic [PIX_W-1:0] win [9];

  assign o_pixel_ready    = (state == ST_FILL);
  assign o_gradient_start = (state == ST_ISSUE);
  assign accept           = i_pixel_valid && o_pixel_ready;
  assign last_col         = (col == COL_LAST);
  assign last_pix         = last_col && (row == ROW_LAST);
  // Only windows fully inside the image are issued; there is no border padding.
  assign win_done         = accept && (row >= RW'(2)) && (col >= CW'(2));

  // lb1 holds row r-1; its old byte cascades into lb2, which holds row r-2.
  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (i_pixel),
    .rdata (rd1)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (rd1),
    .rdata (rd2)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_pix ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_FILL;
    end else begin
      case (state)
        ST_FILL:      if (win_done) state <= ST_ISSUE;
        ST_ISSUE:     state <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (i_gradient_data_ready) state <= ST_FILL;
        default:      state <= ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= accept && last_pix;
    end
  end

  // Window only moves on acceptance, so it is frozen while a window is in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (accept) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= rd2;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= rd1;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= i_pixel;
    end
  end

  assign P0 = win[0];
  assign P1 = win[1];
  assign P2 = win[2];
  assign P3 = win[3];
  assign P4 = win[4];
  assign P5 = win[5];
  assign P6 = win[6];
  assign P7 = win[7];
  assign P8 = win[8];

`ifdef WINDOW_COUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_window_count <= '0;
    end else if (o_frame_done) begin
      o_window_count <= '0;
    end else if (o_gradient_start && (o_window_count != 16'hFFFF)) begin
      o_window_count <= o_window_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image with an image-level reference model.
module tb_sobel_window_buffer;

  localparam int W = 4;
  localparam int H = 4;
  localparam logic [71:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
  localparam logic [71:0] LAST_WIN  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
  localparam logic [71:0] RST_WIN   = {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106,
                                       8'd108, 8'd109, 8'd110};

  logic       clk = 1'b0;
  logic       n_rst;
  logic       i_pixel_valid;
  logic [7:0] i_pixel;
  logic       o_pixel_ready;
  logic       i_gradient_data_ready;
  logic       o_gradient_start;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       o_frame_done;
`ifdef WINDOW_COUNT_EN
  logic [15:0] o_window_count;
`endif

  always #5 clk = ~clk;

  sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .i_pixel_valid         (i_pixel_valid),
    .i_pixel               (i_pixel),
    .o_pixel_ready         (o_pixel_ready),
    .i_gradient_data_ready (i_gradient_data_ready),
    .o_gradient_start      (o_gradient_start),
    .P0                    (P0),
    .P1                    (P1),
    .P2                    (P2),
    .P3                    (P3),
    .P4                    (P4),
    .P5                    (P5),
    .P6                    (P6),
    .P7                    (P7),
    .P8                    (P8),
`ifdef WINDOW_COUNT_EN
    .o_window_count        (o_window_count),
`endif
    .o_frame_done          (o_frame_done)
  );

  logic        man_done   = 1'b0;
  logic        auto_pulse = 1'b0;
  logic        auto_done  = 1'b1;
  int          done_dly   = 3;
  logic        chk_en     = 1'b0;
  logic [71:0] dut_win;

  assign i_gradient_data_ready = man_done | auto_pulse;
  assign dut_win = {P0, P1, P2, P3, P4, P5, P6, P7, P8};

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the image seen so far plus the handshake phase, advanced each rising edge.
  logic [7:0]  img [W*H];
  int          m_idx       = 0;
  logic        m_blocked   = 1'b0;
  logic        m_waiting   = 1'b0;
  logic        m_start_now = 1'b0;
  logic        m_fd_now    = 1'b0;
  logic [71:0] m_win       = '0;
  int          m_wc        = 0;

  always @(posedge clk) begin
    logic acc, n_start, n_fd;
    int   r, c;
    if (!n_rst) begin
      m_idx = 0; m_blocked = 0; m_waiting = 0;
      m_start_now = 0; m_fd_now = 0; m_win = '0; m_wc = 0;
    end else begin
      acc = i_pixel_valid && !m_blocked;
      n_start = 0;
      n_fd = 0;
      if (m_fd_now) m_wc = 0;
      else if (m_start_now && m_wc != 65535) m_wc++;
      if (m_start_now) m_waiting = 1;
      else if (m_waiting && i_gradient_data_ready) begin
        m_waiting = 0;
        m_blocked = 0;
      end
      if (acc) begin
        r = m_idx / W;
        c = m_idx % W;
        img[m_idx] = i_pixel;
        if (r >= 2 && c >= 2) begin
          n_start = 1;
          m_blocked = 1;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              m_win[71-8*(dr*3+dc) -: 8] = img[(r-2+dr)*W + (c-2+dc)];
        end
        if (m_idx == W*H-1) begin
          m_idx = 0;
          n_fd = 1;
        end else begin
          m_idx++;
        end
      end
      m_start_now = n_start;
      m_fd_now = n_fd;
    end
  end

  logic [71:0] wins[$];
  logic [71:0] wins_a[$];
  logic        fd_with_start = 1'b0;
  logic        wc_after = 1'b0;

  always @(negedge clk) begin
    if (n_rst && chk_en) begin
      chk1("ready", o_pixel_ready, !m_blocked);
      chk1("start", o_gradient_start, m_start_now);
      chk1("frame_done", o_frame_done, m_fd_now);
      if (m_blocked) chkw("window", dut_win, m_win);
`ifdef WINDOW_COUNT_EN
      chki("window_count", int'(o_window_count), m_wc);
      if (wc_after) chki("wc_after_frame_done", int'(o_window_count), 0);
      if (o_gradient_start && o_frame_done) chki("wc_final_issue", int'(o_window_count), 3);
      wc_after = o_frame_done;
`endif
      if (o_gradient_start) begin
        wins.push_back(dut_win);
        if (o_frame_done) fd_with_start = 1;
      end
    end
  end

  // Gradient core stand-in: returns done a fixed number of cycles after each start.
  always @(negedge clk) begin
    if (n_rst && auto_done && o_gradient_start) begin
      repeat (done_dly) @(negedge clk);
      auto_pulse = 1'b1;
      @(negedge clk);
      auto_pulse = 1'b0;
    end
  end

  task automatic push(input int v, input logic gap);
    int t;
    t = 0;
    i_pixel = 8'(v);
    i_pixel_valid = 1'b1;
    while (!o_pixel_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk1("push_timeout", t < 500, 1'b1);
    @(negedge clk);
    if (gap) begin
      i_pixel_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_blocked || m_waiting) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk1("idle_timeout", t < 500, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input int base, input logic gap);
    wins.delete();
    fd_with_start = 1'b0;
    for (int k = 0; k < W*H; k++) push(base + k, gap);
    i_pixel_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    n_rst = 1'b0;
    i_pixel_valid = 1'b0;
    i_pixel = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk1("rst_ready", o_pixel_ready, 1'b1);
    chk1("rst_start", o_gradient_start, 1'b0);
    chk1("rst_frame_done", o_frame_done, 1'b0);
    chkw("rst_window", dut_win, 72'd0);
    chk_en = 1'b1;

    // Stray done while filling must be ignored.
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;

    run_frame(0, 1'b0);
    chki("a_starts", wins.size(), 4);
    if (wins.size() == 4) begin
      chkw("a_first_window", wins[0], FIRST_WIN);
      chkw("a_last_window", wins[3], LAST_WIN);
    end
    chk1("a_frame_done_with_issue", fd_with_start, 1'b1);
    wins_a = wins;

    run_frame(0, 1'b1);
    chki("b_starts", wins.size(), 4);
    if (wins.size() == 4 && wins_a.size() == 4)
      for (int i = 0; i < 4; i++) chkw("b_gap_sequence", wins[i], wins_a[i]);

    // Done withheld for 20 cycles while valid stays high with a junk pixel.
    auto_done = 1'b0;
    wins.delete();
    for (int k = 0; k <= 10; k++) push(k, 1'b0);
    i_pixel = 8'hEE;
    i_pixel_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk1("held_ready", o_pixel_ready, 1'b0);
      chkw("held_window", dut_win, FIRST_WIN);
    end
    i_pixel_valid = 1'b0;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    auto_done = 1'b1;
    for (int k = 11; k < W*H; k++) push(k, 1'b0);
    i_pixel_valid = 1'b0;
    wait_idle();
    chki("c_starts", wins.size(), 4);
    if (wins.size() == 4) chkw("c_last_window", wins[3], LAST_WIN);

    // Reset while waiting for done abandons the window; next frame starts fresh.
    auto_done = 1'b0;
    for (int k = 0; k <= 10; k++) push(k, 1'b0);
    i_pixel_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk1("mid_rst_ready", o_pixel_ready, 1'b1);
    chk1("mid_rst_start", o_gradient_start, 1'b0);
    chkw("mid_rst_window", dut_win, 72'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    auto_done = 1'b1;
    @(negedge clk);
    run_frame(100, 1'b0);
    chki("d_starts", wins.size(), 4);
    if (wins.size() == 4) chkw("d_first_window", wins[0], RST_WIN);
    chk1("d_frame_done_with_issue", fd_with_start, 1'b1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per row (range 3..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (range 3..1024).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_pixel_valid, input, 1, upstream pixel present.
REQ-006 SHALL have port i_pixel, input, 8, unsigned grey pixel, raster order.
REQ-007 SHALL have port o_pixel_ready, output, 1, buffer accepts i_pixel this cycle.
REQ-008 SHALL have port i_gradient_data_ready, input, 1, one-cycle done pulse from the downstream gradient core.
REQ-009 SHALL have port o_gradient_start, output, 1, one-cycle window-valid pulse to the gradient core.
REQ-010 SHALL have ports P0..P8, output, 8 each, 3x3 window: P0-P2 oldest row, P6-P8 newest row, P2/P5/P8 newest column.
REQ-011 SHALL have port o_frame_done, output, 1, one-cycle pulse after the last frame pixel is accepted.

Function
REQ-012 SHALL accept a pixel only on a cycle where i_pixel_valid and o_pixel_ready are both 1.
REQ-013 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) counters, advancing col per accepted pixel, wrapping col to 0 and incrementing row.
REQ-014 SHALL keep two line buffers of IMG_WIDTH bytes holding rows r-1 and r-2; on acceptance it SHALL read both at index col and write the new pixel, shifting row r-1 into r-2.
REQ-015 SHALL shift the 3x3 window left by one column on each acceptance, loading column {row r-2, row r-1, new pixel} into P2/P5/P8.
REQ-016 SHALL implement FSM states FILL, ISSUE, WAIT_DONE.
REQ-017 FILL: o_pixel_ready=1; an acceptance with row>=2 and col>=2 SHALL go to ISSUE; otherwise FILL is retained.
REQ-018 ISSUE: o_gradient_start=1 for exactly one cycle, o_pixel_ready=0, then WAIT_DONE.
REQ-019 WAIT_DONE: o_pixel_ready=0 until i_gradient_data_ready=1, then FILL on the next cycle.
REQ-020 P0..P8 SHALL remain stable from ISSUE until the exit from WAIT_DONE.
REQ-021 Acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) SHALL clear row/col to 0 and pulse o_frame_done on the following cycle, coincident with that window's ISSUE.
REQ-022 i_gradient_data_ready outside WAIT_DONE SHALL be ignored.
REQ-023 Windows with row<2 or col<2 SHALL NOT be issued; no border padding is applied.
REQ-024 Latency from accepting the window-completing pixel to o_gradient_start SHALL be exactly 1 cycle.

Reset
REQ-025 On n_rst=0, the block SHALL enter FILL, clear row/col, P0..P8=0, o_gradient_start=0, o_frame_done=0, o_pixel_ready=1 after release; line buffer contents need not be cleared.
REQ-026 A reset in ISSUE or WAIT_DONE SHALL abandon the pending window; the next frame starts at row 0, col 0.

Configuration
REQ-027 With WINDOW_COUNT_EN defined, the block SHALL add output o_window_count (16 bits, reset 0), incremented on each o_gradient_start, cleared on the o_frame_done cycle and saturating at 16'hFFFF.
REQ-028 Without WINDOW_COUNT_EN, the port and counter SHALL be absent.

Structure
REQ-029 The shared package sobel_pkg SHALL hold the FSM state typedef, the pixel width constant (8) and the default image dimensions.
REQ-030 Each line buffer SHALL be an instance of sub-module sobel_line_buffer (IMG_WIDTH x 8, one read and one write port at the same index per cycle, read-before-write).

Verification
REQ-031 IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed with done returned 3 cycles after each start -> exactly 4 starts; the first window is P0..P8 = 0,1,2,4,5,6,8,9,10.
REQ-032 Same stream -> the last window is 5,6,7,9,10,11,13,14,15, and o_frame_done pulses coincident with its ISSUE.
REQ-033 Done withheld for 20 cycles -> o_pixel_ready=0 and P0..P8 unchanged throughout; i_pixel_valid is ignored.
REQ-034 i_pixel_valid toggling every other cycle -> identical window sequence to the back-to-back case.
REQ-035 Reset asserted in WAIT_DONE, then a new frame of 100+k -> the first window is 100,101,102,104,105,106,108,109,110.
REQ-036 With WINDOW_COUNT_EN, a 4x4 frame -> o_window_count reaches 3 before the final ISSUE cycle and reads 0 in the cycle after o_frame_done.
